hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage MIPS core. Tracks in-flight writers of E/M/W
//  (dest reg + Tnew), drives the D->E stall/bubble (stall into Eregs) and the D- and E-stage
//  forwarding selects. Also times the multi-cycle mult/div unit and stalls HI/LO users.
// PARAMETERS
//  MULT_LAT  5   busy cycles after mult/multu leaves E
//  DIV_LAT   10  busy cycles after div/divu leaves E
// PORTS
//  clk        in  1  clock
//  reset      in  1  sync active-high reset
//  rs_d/rt_d  in  5  source regs of instr in D
//  tuse_rs_d  in  2  cycles until D instr needs rs (0=D, 1=E, 2=M)
//  tuse_rt_d  in  2  as above, rt
//  use_rs_d   in  1  D instr reads rs (use_rt_d: same for rt)
//  a3_d       in  5  D instr dest reg (0 = no write)
//  tnew_d     in  2  cycles until result exists, counted while instr sits in E (lw=2, ALU=1, jal/jalr=0)
//  md_use_d   in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
//  md_start_e in  1  instr in E starts mult/div this cycle
//  md_div_e   in  1  that start is a divide
//  stall      out 1  freeze PC/Dregs, bubble Eregs
//  fwd_rs_d   out 2  D-stage rs mux: 00 RF, 01 W, 10 M, 11 E (fwd_rt_d: same, rt)
//  fwd_rs_e   out 2  E-stage rs mux: 00 keep, 01 W, 10 M (fwd_rt_e: same, rt)
//  md_busy    out 1  mult/div counter non-zero
//  stall_cnt  out 32 stall-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  - Scoreboard slots E,M,W = {a3[4:0], tnew[1:0]} plus rs_e/rt_e; all reset to 0.
//  - Each posedge, no reset: W<={M.a3,dec(M.tnew)}; M<={E.a3,dec(E.tnew)};
//    E<= stall ? 0 : {a3_d,tnew_d,rs_d,rt_d}. dec(t)=t?t-1:0.
//  - a3==0 never matches (register $0 is never a hazard source; no fwd).
//  - stall_rs = use_rs_d & rs_d!=0 & ((E.a3==rs_d & E.tnew>tuse_rs_d) | (M.a3==rs_d & M.tnew>tuse_rs_d)); rt likewise.
//  - md_stall = md_use_d & (md_busy | md_start_e). stall = stall_rs|stall_rt|md_stall.
//  - stall, fwd_*: combinational from slots + D inputs, same cycle.
//  - fwd_*_d priority: E(tnew==0) > M(tnew==0) > W > RF. fwd_*_e: M(tnew==0) > W > keep.
//  - MD counter: load MULT_LAT/DIV_LAT when md_start_e; else decrement while non-zero.
//    Start while busy reloads (illegal in flow; bench asserts it never occurs).
//  - Reset mid-operation clears all slots, counter, stall_cnt next edge; outputs then 0.
// CONFIGURATION
//  HAZARD_STAT_EN defined: stall_cnt increments (wraps at 2^32) each non-reset cycle with stall=1.
//  Undefined: no counter logic; stall_cnt driven 32'b0.
// STRUCTURE
//  hazard_pkg: Tnew/Tuse width, FWD_RF/FWD_W/FWD_M/FWD_E codes, default latencies.
//  Sub-module md_busy_timer (load value, start, busy out); rest flat.
// TESTING
//  lw $1,0($0); addu $2,$1,$3 -> stall=1 one cycle; next cycle addu in E: fwd_rs_e=01.
//  addu $1,..; beq $1,$2 -> stall=1 one cycle; then fwd_rs_d=10, stall=0.
//  jal f; jr $31 (delay slot) -> stall=0, fwd_rs_d=11 while jal in E.
//  ori $0,$0,5; beq $0,$0 -> stall=0, fwd_rs_d=00.
//  mult $1,$2; mflo $3 -> stall=1 while mult in E, then MULT_LAT=5 further cycles; stall=0 when md_busy=0.
//  div started then reset=1 mid-count -> md_busy=0, stall=0, slots 0 next cycle; stall_cnt=0 (STAT_EN).

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared widths, forwarding-mux codes and default mult/div latencies for the hazard controller.
package hazard_pkg;

    localparam int unsigned REG_W     = 5;
    localparam int unsigned T_W       = 2;
    localparam int unsigned FWD_SEL_W = 2;
    localparam int unsigned STAT_W    = 32;
    localparam int unsigned MD_CNT_W  = 8;

    localparam logic [FWD_SEL_W-1:0] FWD_RF = 2'b00;
    localparam logic [FWD_SEL_W-1:0] FWD_W  = 2'b01;
    localparam logic [FWD_SEL_W-1:0] FWD_M  = 2'b10;
    localparam logic [FWD_SEL_W-1:0] FWD_E  = 2'b11;

    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    typedef struct packed {
        logic [REG_W-1:0] a3;
        logic [T_W-1:0]   tnew;
    } slot_t;

    // Tnew ages by one per stage and saturates at zero.
    function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
        return (t != '0) ? t - T_W'(1) : '0;
    endfunction

    // Register $0 is never a hazard or forwarding source.
    function automatic logic reg_hit(input logic [REG_W-1:0] a3, input logic [REG_W-1:0] r);
        return (a3 != '0) && (a3 == r);
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Down-counter that models the multi-cycle mult/div unit; busy while the count is non-zero.
module md_busy_timer
    import hazard_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [MD_CNT_W-1:0] load_val_i,
    output logic                busy_o
);

    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic                busy_q;

    // A start always reloads, even if the unit is still counting.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - MD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forwarding control for the 5-stage MIPS pipeline plus mult/div busy timing.
// Optional stall statistics counter enabled by defining HAZARD_STAT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_W-1:0]     rs_d,
    input  logic [REG_W-1:0]     rt_d,
    input  logic [T_W-1:0]       tuse_rs_d,
    input  logic [T_W-1:0]       tuse_rt_d,
    input  logic                 use_rs_d,
    input  logic                 use_rt_d,
    input  logic [REG_W-1:0]     a3_d,
    input  logic [T_W-1:0]       tnew_d,
    input  logic                 md_use_d,
    input  logic                 md_start_e,
    input  logic                 md_div_e,
    output logic                 stall,
    output logic [FWD_SEL_W-1:0] fwd_rs_d,
    output logic [FWD_SEL_W-1:0] fwd_rt_d,
    output logic [FWD_SEL_W-1:0] fwd_rs_e,
    output logic [FWD_SEL_W-1:0] fwd_rt_e,
    output logic                 md_busy,
    output logic [STAT_W-1:0]    stall_cnt
);

    slot_t            e_q, e_d, m_q, m_d;
    logic [REG_W-1:0] w_a3_q, w_a3_d;
    logic [REG_W-1:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d;

    logic stall_rs, stall_rt, md_stall;

    // Stall when a producer still in E or M cannot deliver before the D instr needs it.
    always_comb begin
        stall_rs = use_rs_d && (rs_d != '0) &&
                   ((reg_hit(e_q.a3, rs_d) && (e_q.tnew > tuse_rs_d)) ||
                    (reg_hit(m_q.a3, rs_d) && (m_q.tnew > tuse_rs_d)));
        stall_rt = use_rt_d && (rt_d != '0) &&
                   ((reg_hit(e_q.a3, rt_d) && (e_q.tnew > tuse_rt_d)) ||
                    (reg_hit(m_q.a3, rt_d) && (m_q.tnew > tuse_rt_d)));
        md_stall = md_use_d && (md_busy || md_start_e);
        stall    = stall_rs || stall_rt || md_stall;
    end

    // Youngest ready producer wins.
    always_comb begin
        fwd_rs_d = FWD_RF;
        if (reg_hit(e_q.a3, rs_d) && (e_q.tnew == '0)) begin
            fwd_rs_d = FWD_E;
        end else if (reg_hit(m_q.a3, rs_d) && (m_q.tnew == '0)) begin
            fwd_rs_d = FWD_M;
        end else if (reg_hit(w_a3_q, rs_d)) begin
            fwd_rs_d = FWD_W;
        end

        fwd_rt_d = FWD_RF;
        if (reg_hit(e_q.a3, rt_d) && (e_q.tnew == '0)) begin
            fwd_rt_d = FWD_E;
        end else if (reg_hit(m_q.a3, rt_d) && (m_q.tnew == '0)) begin
            fwd_rt_d = FWD_M;
        end else if (reg_hit(w_a3_q, rt_d)) begin
            fwd_rt_d = FWD_W;
        end

        fwd_rs_e = FWD_RF;
        if (reg_hit(m_q.a3, rs_e_q) && (m_q.tnew == '0)) begin
            fwd_rs_e = FWD_M;
        end else if (reg_hit(w_a3_q, rs_e_q)) begin
            fwd_rs_e = FWD_W;
        end

        fwd_rt_e = FWD_RF;
        if (reg_hit(m_q.a3, rt_e_q) && (m_q.tnew == '0)) begin
            fwd_rt_e = FWD_M;
        end else if (reg_hit(w_a3_q, rt_e_q)) begin
            fwd_rt_e = FWD_W;
        end
    end

    // Scoreboard advance; a stall injects an empty slot into E.
    always_comb begin
        w_a3_d = m_q.a3;
        m_d    = '{a3: e_q.a3, tnew: tnew_dec(e_q.tnew)};
        e_d    = '{a3: a3_d, tnew: tnew_d};
        rs_e_d = rs_d;
        rt_e_d = rt_d;
        if (stall) begin
            e_d    = '0;
            rs_e_d = '0;
            rt_e_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q    <= '0;
            m_q    <= '0;
            w_a3_q <= '0;
            rs_e_q <= '0;
            rt_e_q <= '0;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_a3_q <= w_a3_d;
            rs_e_q <= rs_e_d;
            rt_e_q <= rt_e_d;
        end
    end

    md_busy_timer u_md_busy_timer (
        .clk        (clk),
        .reset      (reset),
        .start_i    (md_start_e),
        .load_val_i (md_div_e ? MD_CNT_W'(DIV_LAT) : MD_CNT_W'(MULT_LAT)),
        .busy_o     (md_busy)
    );

`ifdef HAZARD_STAT_EN
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
